ex_stage: RTL and testbench

Execute stage of the five-stage MIPS pipeline, including its EX/MEM pipeline register. Consumes the control, operand, immediate and register-index outputs of the ID/EX register and resolves operand forwarding. Performs ALU control decode, the ALU operation and branch-target/zero evaluation. Registers everything the MEM stage needs on the next rising clock edge.

---
 rtl/ex_stage_if.sv | 53 +++++
 rtl/ex_stage.sv | 139 +++++++++++++
 tb/tb_ex_stage.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/ex_stage_if.sv
// rtl/ex_stage_if.sv - ID/EX, MEM/WB forwarding and EX/MEM register bundle for the execute stage
interface ex_stage_if;
  logic [31:0] id_ex_pc;
  logic [31:0] id_ex_reg1;
  logic [31:0] id_ex_reg2;
  logic [31:0] id_ex_sign_ext;
  logic [4:0]  id_ex_rs;
  logic [4:0]  id_ex_rt;
  logic [4:0]  id_ex_rd;
  logic [1:0]  id_ex_alu_op;
  logic        id_ex_reg_dst;
  logic        id_ex_alu_src;
  logic        id_ex_mem_to_reg;
  logic        id_ex_reg_write;
  logic        id_ex_mem_read;
  logic        id_ex_mem_write;
  logic        id_ex_branch;
  logic        mem_wb_reg_write;
  logic [4:0]  mem_wb_dst;
  logic [31:0] mem_wb_data;
  logic [31:0] ex_mem_alu_result;
  logic [31:0] ex_mem_store_data;
  logic [31:0] ex_mem_branch_target;
  logic [4:0]  ex_mem_dst;
  logic        ex_mem_zero;
  logic        ex_mem_pc_src;
  logic        ex_mem_mem_to_reg;
  logic        ex_mem_reg_write;
  logic        ex_mem_mem_read;
  logic        ex_mem_mem_write;

  modport master (
    output id_ex_pc, id_ex_reg1, id_ex_reg2, id_ex_sign_ext,
    output id_ex_rs, id_ex_rt, id_ex_rd, id_ex_alu_op,
    output id_ex_reg_dst, id_ex_alu_src, id_ex_mem_to_reg, id_ex_reg_write,
    output id_ex_mem_read, id_ex_mem_write, id_ex_branch,
    output mem_wb_reg_write, mem_wb_dst, mem_wb_data,
    input  ex_mem_alu_result, ex_mem_store_data, ex_mem_branch_target, ex_mem_dst,
    input  ex_mem_zero, ex_mem_pc_src, ex_mem_mem_to_reg, ex_mem_reg_write,
    input  ex_mem_mem_read, ex_mem_mem_write
  );

  modport slave (
    input  id_ex_pc, id_ex_reg1, id_ex_reg2, id_ex_sign_ext,
    input  id_ex_rs, id_ex_rt, id_ex_rd, id_ex_alu_op,
    input  id_ex_reg_dst, id_ex_alu_src, id_ex_mem_to_reg, id_ex_reg_write,
    input  id_ex_mem_read, id_ex_mem_write, id_ex_branch,
    input  mem_wb_reg_write, mem_wb_dst, mem_wb_data,
    output ex_mem_alu_result, ex_mem_store_data, ex_mem_branch_target, ex_mem_dst,
    output ex_mem_zero, ex_mem_pc_src, ex_mem_mem_to_reg, ex_mem_reg_write,
    output ex_mem_mem_read, ex_mem_mem_write
  );
endinterface

// File: rtl/ex_stage.sv
// rtl/ex_stage.sv - MIPS execute stage: forwarding, ALU, branch target and EX/MEM register
module ex_stage (
  input logic      clk,
  input logic      reset,
  input logic      flush,
  ex_stage_if.slave bus
);
  localparam logic [2:0] ALU_ADD  = 3'd0;
  localparam logic [2:0] ALU_SUB  = 3'd1;
  localparam logic [2:0] ALU_AND  = 3'd2;
  localparam logic [2:0] ALU_OR   = 3'd3;
  localparam logic [2:0] ALU_NOR  = 3'd4;
  localparam logic [2:0] ALU_SLT  = 3'd5;
  localparam logic [2:0] ALU_ZERO = 3'd6;

  logic [31:0] r_alu_result;
  logic [31:0] r_store_data;
  logic [31:0] r_branch_target;
  logic [4:0]  r_dst;
  logic        r_zero;
  logic        r_pc_src;
  logic        r_mem_to_reg;
  logic        r_reg_write;
  logic        r_mem_read;
  logic        r_mem_write;

  logic [31:0] w_op_a;
  logic [31:0] w_fwd_b;
  logic [31:0] w_op_b;
  logic [2:0]  w_alu_sel;
  logic [31:0] w_alu_result;
  logic        w_zero;
  logic [4:0]  w_dst;
  logic [31:0] w_branch_target;

  // EX/MEM is checked before MEM/WB so the younger producer always wins
  always_comb begin
    if (r_reg_write && (r_dst != 5'd0) && (r_dst == bus.id_ex_rs))
      w_op_a = r_alu_result;
    else if (bus.mem_wb_reg_write && (bus.mem_wb_dst != 5'd0) && (bus.mem_wb_dst == bus.id_ex_rs))
      w_op_a = bus.mem_wb_data;
    else
      w_op_a = bus.id_ex_reg1;
  end

  always_comb begin
    if (r_reg_write && (r_dst != 5'd0) && (r_dst == bus.id_ex_rt))
      w_fwd_b = r_alu_result;
    else if (bus.mem_wb_reg_write && (bus.mem_wb_dst != 5'd0) && (bus.mem_wb_dst == bus.id_ex_rt))
      w_fwd_b = bus.mem_wb_data;
    else
      w_fwd_b = bus.id_ex_reg2;
  end

  assign w_op_b = bus.id_ex_alu_src ? bus.id_ex_sign_ext : w_fwd_b;

  always_comb begin
    w_alu_sel = ALU_ADD;
    case (bus.id_ex_alu_op)
      2'b00: w_alu_sel = ALU_ADD;
      2'b01: w_alu_sel = ALU_SUB;
      2'b11: w_alu_sel = ALU_ADD;
      default: begin
        case (bus.id_ex_sign_ext[5:0])
          6'h20:   w_alu_sel = ALU_ADD;
          6'h22:   w_alu_sel = ALU_SUB;
          6'h24:   w_alu_sel = ALU_AND;
          6'h25:   w_alu_sel = ALU_OR;
          6'h27:   w_alu_sel = ALU_NOR;
          6'h2A:   w_alu_sel = ALU_SLT;
          default: w_alu_sel = ALU_ZERO;
        endcase
      end
    endcase
  end

  always_comb begin
    w_alu_result = 32'h0;
    case (w_alu_sel)
      ALU_ADD: w_alu_result = w_op_a + w_op_b;
      ALU_SUB: w_alu_result = w_op_a - w_op_b;
      ALU_AND: w_alu_result = w_op_a & w_op_b;
      ALU_OR:  w_alu_result = w_op_a | w_op_b;
      ALU_NOR: w_alu_result = ~(w_op_a | w_op_b);
      ALU_SLT: w_alu_result = ($signed(w_op_a) < $signed(w_op_b)) ? 32'h1 : 32'h0;
      default: w_alu_result = 32'h0;
    endcase
  end

  assign w_zero          = (w_alu_result == 32'h0);
  assign w_dst           = bus.id_ex_reg_dst ? bus.id_ex_rd : bus.id_ex_rt;
  assign w_branch_target = bus.id_ex_pc + {bus.id_ex_sign_ext[29:0], 2'b00};

  // A flush keeps the datapath but clears every control bit, so the bubble never forwards
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_alu_result    <= 32'h0;
      r_store_data    <= 32'h0;
      r_branch_target <= 32'h0;
      r_dst           <= 5'd0;
      r_zero          <= 1'b0;
      r_pc_src        <= 1'b0;
      r_mem_to_reg    <= 1'b0;
      r_reg_write     <= 1'b0;
      r_mem_read      <= 1'b0;
      r_mem_write     <= 1'b0;
    end else begin
      r_alu_result    <= w_alu_result;
      r_store_data    <= w_fwd_b;
      r_branch_target <= w_branch_target;
      r_dst           <= w_dst;
      r_zero          <= w_zero;
      if (flush) begin
        r_pc_src     <= 1'b0;
        r_mem_to_reg <= 1'b0;
        r_reg_write  <= 1'b0;
        r_mem_read   <= 1'b0;
        r_mem_write  <= 1'b0;
      end else begin
        r_pc_src     <= bus.id_ex_branch & w_zero;
        r_mem_to_reg <= bus.id_ex_mem_to_reg;
        r_reg_write  <= bus.id_ex_reg_write;
        r_mem_read   <= bus.id_ex_mem_read;
        r_mem_write  <= bus.id_ex_mem_write;
      end
    end
  end

  assign bus.ex_mem_alu_result    = r_alu_result;
  assign bus.ex_mem_store_data    = r_store_data;
  assign bus.ex_mem_branch_target = r_branch_target;
  assign bus.ex_mem_dst           = r_dst;
  assign bus.ex_mem_zero          = r_zero;
  assign bus.ex_mem_pc_src        = r_pc_src;
  assign bus.ex_mem_mem_to_reg    = r_mem_to_reg;
  assign bus.ex_mem_reg_write     = r_reg_write;
  assign bus.ex_mem_mem_read      = r_mem_read;
  assign bus.ex_mem_mem_write     = r_mem_write;
endmodule

// File: tb/tb_ex_stage.sv
// tb/tb_ex_stage.sv - directed vector bench for the execute stage
module tb_ex_stage;
  logic clk = 1'b0;
  logic reset;
  logic flush;
  int   errors = 0;
  int   checks = 0;

  ex_stage_if bus ();

  ex_stage dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  alu_op;
    logic [31:0] imm;
    logic [31:0] reg1;
    logic [31:0] reg2;
    logic        alu_src;
    logic        reg_dst;
    logic [31:0] exp_res;
    logic [4:0]  exp_dst;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle();
    bus.id_ex_pc         = 32'h100;
    bus.id_ex_reg1       = 32'h0;
    bus.id_ex_reg2       = 32'h0;
    bus.id_ex_sign_ext   = 32'h0;
    bus.id_ex_rs         = 5'd0;
    bus.id_ex_rt         = 5'd0;
    bus.id_ex_rd         = 5'd0;
    bus.id_ex_alu_op     = 2'b00;
    bus.id_ex_reg_dst    = 1'b0;
    bus.id_ex_alu_src    = 1'b0;
    bus.id_ex_mem_to_reg = 1'b0;
    bus.id_ex_reg_write  = 1'b0;
    bus.id_ex_mem_read   = 1'b0;
    bus.id_ex_mem_write  = 1'b0;
    bus.id_ex_branch     = 1'b0;
    bus.mem_wb_reg_write = 1'b0;
    bus.mem_wb_dst       = 5'd0;
    bus.mem_wb_data      = 32'h0;
    flush                = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rtype(input logic [5:0] funct, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [31:0] r1, input logic [31:0] r2);
    idle();
    bus.id_ex_alu_op    = 2'b10;
    bus.id_ex_sign_ext  = {26'h0, funct};
    bus.id_ex_rs        = rs;
    bus.id_ex_rt        = rt;
    bus.id_ex_rd        = rd;
    bus.id_ex_reg1      = r1;
    bus.id_ex_reg2      = r2;
    bus.id_ex_reg_dst   = 1'b1;
    bus.id_ex_reg_write = 1'b1;
  endtask

  initial begin
    vecs[0]  = '{2'b10, 32'h20, 32'd5, 32'd7, 1'b0, 1'b1, 32'd12, 5'd9};
    vecs[1]  = '{2'b10, 32'h22, 32'd5, 32'd7, 1'b0, 1'b1, 32'hFFFFFFFE, 5'd9};
    vecs[2]  = '{2'b10, 32'h24, 32'hF0F0, 32'hFF00, 1'b0, 1'b1, 32'hF000, 5'd9};
    vecs[3]  = '{2'b10, 32'h25, 32'hF0F0, 32'h0F0F, 1'b0, 1'b1, 32'hFFFF, 5'd9};
    vecs[4]  = '{2'b10, 32'h27, 32'hF0F0F0F0, 32'h0F0F0F00, 1'b0, 1'b1, 32'h0000000F, 5'd9};
    vecs[5]  = '{2'b10, 32'h2A, 32'hFFFFFFFF, 32'd1, 1'b0, 1'b1, 32'd1, 5'd9};
    vecs[6]  = '{2'b10, 32'h2A, 32'd1, 32'hFFFFFFFF, 1'b0, 1'b1, 32'd0, 5'd9};
    vecs[7]  = '{2'b10, 32'h3F, 32'd5, 32'd7, 1'b0, 1'b1, 32'd0, 5'd9};
    vecs[8]  = '{2'b00, 32'h8, 32'h1000, 32'h1234, 1'b1, 1'b0, 32'h1008, 5'd0};
    vecs[9]  = '{2'b01, 32'h0, 32'd6, 32'd6, 1'b0, 1'b0, 32'd0, 5'd0};
    vecs[10] = '{2'b11, 32'h0, 32'hFFFFFFFF, 32'd1, 1'b0, 1'b0, 32'd0, 5'd0};
    vecs[11] = '{2'b10, 32'h20, 32'h80000000, 32'h80000000, 1'b0, 1'b1, 32'd0, 5'd9};

    idle();
    reset = 1'b1;
    #2;
    check("reset_alu", bus.ex_mem_alu_result, 32'h0);
    check("reset_ctl", {27'h0, bus.ex_mem_reg_write, bus.ex_mem_mem_read, bus.ex_mem_mem_write,
                        bus.ex_mem_mem_to_reg, bus.ex_mem_pc_src}, 32'h0);
    #10 reset = 1'b0;

    for (int i = 0; i < 12; i++) begin
      idle();
      bus.id_ex_alu_op   = vecs[i].alu_op;
      bus.id_ex_sign_ext = vecs[i].imm;
      bus.id_ex_reg1     = vecs[i].reg1;
      bus.id_ex_reg2     = vecs[i].reg2;
      bus.id_ex_alu_src  = vecs[i].alu_src;
      bus.id_ex_reg_dst  = vecs[i].reg_dst;
      bus.id_ex_rd       = 5'd9;
      step();
      check($sformatf("vec%0d_result", i), bus.ex_mem_alu_result, vecs[i].exp_res);
      check($sformatf("vec%0d_zero", i), {31'h0, bus.ex_mem_zero}, {31'h0, vecs[i].exp_res == 32'h0});
      check($sformatf("vec%0d_dst", i), {27'h0, bus.ex_mem_dst}, {27'h0, vecs[i].exp_dst});
      check($sformatf("vec%0d_store", i), bus.ex_mem_store_data, vecs[i].reg2);
    end

    // reset asserted between edges clears outputs immediately; next edge loads normally
    rtype(6'h20, 5'd0, 5'd0, 5'd7, 32'd20, 32'd22);
    bus.id_ex_mem_read = 1'b1;
    step();
    check("pre_reset_result", bus.ex_mem_alu_result, 32'd42);
    #2 reset = 1'b1;
    #1;
    check("mid_reset_result", bus.ex_mem_alu_result, 32'h0);
    check("mid_reset_dst", {27'h0, bus.ex_mem_dst}, 32'h0);
    check("mid_reset_ctl", {30'h0, bus.ex_mem_reg_write, bus.ex_mem_mem_read}, 32'h0);
    #1 reset = 1'b0;
    rtype(6'h20, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7);
    step();
    check("add_result", bus.ex_mem_alu_result, 32'd12);
    check("add_dst", {27'h0, bus.ex_mem_dst}, 32'd3);
    check("add_reg_write", {31'h0, bus.ex_mem_reg_write}, 32'd1);

    rtype(6'h22, 5'd3, 5'd2, 5'd8, 32'd0, 32'd2);
    step();
    check("sub_fwd_exmem", bus.ex_mem_alu_result, 32'd10);

    // EX/MEM (9) and MEM/WB (1) both target r4; EX/MEM must win
    rtype(6'h20, 5'd0, 5'd0, 5'd4, 32'd4, 32'd5);
    step();
    rtype(6'h20, 5'd4, 5'd0, 5'd0, 32'd100, 32'd0);
    bus.mem_wb_reg_write = 1'b1;
    bus.mem_wb_dst       = 5'd4;
    bus.mem_wb_data      = 32'd1;
    step();
    check("double_hazard", bus.ex_mem_alu_result, 32'd9);
    rtype(6'h20, 5'd0, 5'd0, 5'd0, 32'd100, 32'd0);
    bus.mem_wb_reg_write = 1'b1;
    bus.mem_wb_dst       = 5'd0;
    bus.mem_wb_data      = 32'd1;
    step();
    check("r0_no_forward", bus.ex_mem_alu_result, 32'd100);

    idle();
    bus.id_ex_alu_op   = 2'b01;
    bus.id_ex_reg1     = 32'd6;
    bus.id_ex_reg2     = 32'd6;
    bus.id_ex_sign_ext = 32'hFFFFFFFE;
    bus.id_ex_branch   = 1'b1;
    step();
    check("beq_zero", {31'h0, bus.ex_mem_zero}, 32'd1);
    check("beq_pc_src", {31'h0, bus.ex_mem_pc_src}, 32'd1);
    check("beq_target", bus.ex_mem_branch_target, 32'hF8);

    bus.id_ex_rs        = 5'd5;
    bus.id_ex_rt        = 5'd5;
    bus.id_ex_reg_write = 1'b1;
    bus.id_ex_mem_write = 1'b1;
    flush               = 1'b1;
    step();
    check("flush_pc_src", {31'h0, bus.ex_mem_pc_src}, 32'd0);
    check("flush_ctl", {29'h0, bus.ex_mem_reg_write, bus.ex_mem_mem_write, bus.ex_mem_mem_read}, 32'd0);

    // flushed entry targeting r5 must not forward
    rtype(6'h20, 5'd5, 5'd0, 5'd10, 32'h77, 32'd0);
    step();
    check("flush_no_forward", bus.ex_mem_alu_result, 32'h77);

    idle();
    bus.id_ex_alu_src    = 1'b1;
    bus.id_ex_sign_ext   = 32'd8;
    bus.id_ex_reg1       = 32'h1000;
    bus.id_ex_rt         = 5'd6;
    bus.id_ex_reg2       = 32'h5555;
    bus.id_ex_mem_write  = 1'b1;
    bus.mem_wb_reg_write = 1'b1;
    bus.mem_wb_dst       = 5'd6;
    bus.mem_wb_data      = 32'hABCD;
    step();
    check("sw_addr", bus.ex_mem_alu_result, 32'h1008);
    check("sw_store_fwd", bus.ex_mem_store_data, 32'hABCD);
    check("sw_mem_write", {31'h0, bus.ex_mem_mem_write}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
